multicycle_control: RTL and testbench

Main control FSM for the multicycle LEGv8 datapath, sequencing fetch, decode, execute, memory and writeback over a single shared instruction/data memory. It decodes instr[31:21] (LDUR, STUR, CBZ, ADD, SUB, AND, ORR) and drives the mux selects and write enables of PC, IR, register file, ALU and memory. It stalls on a memory ready handshake. The existing signext, ALU and regfile blocks are the datapath it controls.

---
 rtl/multicycle_control.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle LEGv8 datapath: sequences fetch, decode, execute,
// memory and writeback over one shared memory. Define MC_PERF_CNT_EN to add cycle/instr counters.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_src,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        reg2loc,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic [3:0]  state_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ILLEGAL  = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        OP_LDUR  = 3'd0,
        OP_STUR  = 3'd1,
        OP_CBZ   = 3'd2,
        OP_RTYPE = 3'd3,
        OP_BAD   = 3'd4
    } opclass_e;

    function automatic opclass_e classify(input logic [10:0] opc);
        opclass_e cls;
        if (opc == 11'b11111000010) begin
            cls = OP_LDUR;
        end else if (opc == 11'b11111000000) begin
            cls = OP_STUR;
        end else if (opc[10:3] == 8'b10110100) begin
            cls = OP_CBZ;
        end else if ((opc == 11'b10001011000) || (opc == 11'b11001011000) ||
                     (opc == 11'b10001010000) || (opc == 11'b10101010000)) begin
            cls = OP_RTYPE;
        end else begin
            cls = OP_BAD;
        end
        return cls;
    endfunction

    state_e   state_q;
    state_e   state_d;
    opclass_e opcls_s;
    logic     unused_zero_s;

    assign opcls_s       = classify(op);
    // zero gates pc_write_cond inside the datapath, not here
    assign unused_zero_s = zero;
    assign state_o       = state_q;

    // Next-state selection; mem_ready only matters in the three memory-access states
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready == 1'b1) state_d = S_DECODE;
                else                   state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcls_s)
                    OP_LDUR, OP_STUR: state_d = S_MEMADR;
                    OP_RTYPE:         state_d = S_EXECUTE;
                    OP_CBZ:           state_d = S_BRANCH;
                    default:          state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                if (opcls_s == OP_LDUR)      state_d = S_MEMREAD;
                else if (opcls_s == OP_STUR) state_d = S_MEMWRITE;
                else                         state_d = S_ILLEGAL;
            end
            S_MEMREAD: begin
                if (mem_ready == 1'b1) state_d = S_MEMWB;
                else                   state_d = S_MEMREAD;
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready == 1'b1) state_d = S_FETCH;
                else                   state_d = S_MEMWRITE;
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ILLEGAL: state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    // State register; reset forces IDLE at once, which zeroes every output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control outputs decoded from the current state
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg2loc       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                reg2loc   = (opcls_s == OP_STUR) || (opcls_s == OP_CBZ);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                reg2loc   = (opcls_s == OP_STUR);
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                reg2loc   = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                reg2loc       = 1'b1;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] instr_cnt_q;
    logic             instr_done_s;

    // An instruction retires on leaving a writeback/branch state or when a store completes
    always_comb begin
        instr_done_s = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                       ((state_q == S_MEMWRITE) && (mem_ready == 1'b1));
    end

    // Free-running wrap-around performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_IDLE) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (instr_done_s) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    logic unused_cnt_w_s;
    assign unused_cnt_w_s = (CNT_W != 32'sd0);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level model predicts the state
// sequence and control word of every cycle; literal latencies and counters pin the model.
module tb_multicycle_control;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_MEMADR   = 4'd3;
    localparam logic [3:0] ST_MEMREAD  = 4'd4;
    localparam logic [3:0] ST_MEMWB    = 4'd5;
    localparam logic [3:0] ST_MEMWRITE = 4'd6;
    localparam logic [3:0] ST_EXECUTE  = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_ILLEGAL  = 4'd10;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_CBZA = 11'b10110100101;
    localparam logic [10:0] OP_CBZB = 11'b10110100010;
    localparam logic [10:0] OP_BAD  = 11'b10101010101;

    logic        clk;
    logic        reset;
    logic [10:0] op;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, pc_src, ir_write, iord, mem_read, mem_write;
    logic        reg_write, mem_to_reg, reg2loc, alu_src_a, illegal;
    logic [1:0]  alu_src_b, alu_op;
    logic [3:0]  state_o;
`ifdef MC_PERF_CNT_EN
    logic [3:0]  cycle_cnt, instr_cnt;
`endif

    multicycle_control #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg2loc(reg2loc),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal(illegal), .state_o(state_o)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] outs;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   lat_q[$];
    int   vectors = 0;
    int   errors  = 0;

    logic        rst_v;
    logic [10:0] op_v;
    logic        zero_v;

    logic [15:0] dut_outs;
    assign dut_outs = {pc_write, pc_write_cond, pc_src, ir_write, iord, mem_read, mem_write,
                       reg_write, mem_to_reg, reg2loc, alu_src_a, alu_src_b, alu_op, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word each state must show, straight from the per-state output table
    function automatic logic [15:0] expected_outs(input logic [3:0] st, input logic [10:0] o,
                                                  input logic mr);
        logic pcw, pcwc, pcs, irw, io, mrd, mwr, rw, m2r, r2l, asa, ill;
        logic [1:0] asb, aop;
        logic is_stur, is_cbz;
        {pcw, pcwc, pcs, irw, io, mrd, mwr, rw, m2r, r2l, asa, ill} = 12'd0;
        asb = 2'b00;
        aop = 2'b00;
        is_stur = (o == OP_STUR);
        is_cbz  = (o[10:3] == 8'b10110100);
        case (st)
            ST_FETCH:    begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            ST_DECODE:   begin asb = 2'b11; r2l = is_stur | is_cbz; end
            ST_MEMADR:   begin asa = 1'b1; asb = 2'b10; r2l = is_stur; end
            ST_MEMREAD:  begin mrd = 1'b1; io = 1'b1; end
            ST_MEMWB:    begin rw = 1'b1; m2r = 1'b1; end
            ST_MEMWRITE: begin mwr = 1'b1; io = 1'b1; r2l = 1'b1; end
            ST_EXECUTE:  begin asa = 1'b1; aop = 2'b10; end
            ST_ALUWB:    begin rw = 1'b1; end
            ST_BRANCH:   begin asa = 1'b1; aop = 2'b01; r2l = 1'b1; pcwc = 1'b1; pcs = 1'b1; end
            ST_ILLEGAL:  begin ill = 1'b1; end
            default:     begin ill = 1'b0; end
        endcase
        return {pcw, pcwc, pcs, irw, io, mrd, mwr, rw, m2r, r2l, asa, asb, aop, ill};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        chk_q.push_back('{name: nm, act: a, exp: e});
    endtask

    // One clock cycle: apply inputs just after the edge and record the predicted state/outputs
    task automatic cyc(input logic [3:0] st, input logic mr);
        @(posedge clk);
        #1;
        reset     = rst_v;
        op        = op_v;
        zero      = zero_v;
        mem_ready = mr;
        exp_q.push_back('{st: st, outs: expected_outs(st, op_v, mr)});
    endtask

    // Instruction-level model: the state walk of one instruction given its wait cycles
    task automatic do_instr(input logic [10:0] o, input logic z, input int fw, input int mw);
        op_v   = o;
        zero_v = z;
        for (int i = 0; i < fw; i++) cyc(ST_FETCH, 1'b0);
        cyc(ST_FETCH, 1'b1);
        cyc(ST_DECODE, 1'b0);
        if (o == OP_LDUR) begin
            cyc(ST_MEMADR, 1'b1);
            for (int i = 0; i < mw; i++) cyc(ST_MEMREAD, 1'b0);
            cyc(ST_MEMREAD, 1'b1);
            cyc(ST_MEMWB, 1'b0);
        end else if (o == OP_STUR) begin
            cyc(ST_MEMADR, 1'b0);
            for (int i = 0; i < mw; i++) cyc(ST_MEMWRITE, 1'b0);
            cyc(ST_MEMWRITE, 1'b1);
        end else if (o == OP_ADD || o == OP_SUB || o == OP_AND || o == OP_ORR) begin
            cyc(ST_EXECUTE, 1'b1);
            cyc(ST_ALUWB, 1'b0);
        end else if (o[10:3] == 8'b10110100) begin
            cyc(ST_BRANCH, 1'b1);
        end else begin
            cyc(ST_ILLEGAL, 1'b1);
        end
    endtask

    // Compare process: per-cycle model check, queued point checks, FETCH-to-FETCH latency
    int         ncyc = 0;
    int         fetch_start = 0;
    bit         have_start = 1'b0;
    logic [3:0] prev_st = 4'd0;
    exp_t       e;
    chk_t       c;
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors = vectors + 1;
            if (state_o !== e.st || dut_outs !== e.outs) begin
                errors = errors + 1;
                $display("FAIL cycle %0d: actual state=%0d outs=%b, required state=%0d outs=%b",
                         ncyc, state_o, dut_outs, e.st, e.outs);
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            vectors = vectors + 1;
            if (c.act !== c.exp) begin
                errors = errors + 1;
                $display("FAIL %s: actual %0d required %0d", c.name, c.act, c.exp);
            end
        end
        if (state_o == ST_IDLE) begin
            have_start = 1'b0;
        end else if (state_o == ST_FETCH && prev_st != ST_FETCH) begin
            if (have_start) lat_q.push_back(ncyc - fetch_start);
            fetch_start = ncyc;
            have_start  = 1'b1;
        end
        prev_st = state_o;
    end

    int exp_lat[12] = '{4, 7, 3, 3, 3, 5, 4, 4, 4, 5, 6, 4};

    initial begin
        reset = 1'b0; op = 11'd0; zero = 1'b0; mem_ready = 1'b0;
        rst_v = 1'b0; op_v = 11'd0; zero_v = 1'b0;
        cyc(ST_IDLE, 1'b1);
        cyc(ST_IDLE, 1'b0);
        rst_v = 1'b1;
        cyc(ST_IDLE, 1'b1);

        do_instr(OP_ADD,  1'b0, 0, 0);
        do_instr(OP_LDUR, 1'b0, 0, 2);
        do_instr(OP_CBZA, 1'b1, 0, 0);
        do_instr(OP_CBZB, 1'b0, 0, 0);
        do_instr(OP_BAD,  1'b0, 0, 0);
        do_instr(OP_SUB,  1'b1, 1, 0);
        do_instr(OP_AND,  1'b0, 0, 0);
        do_instr(OP_ORR,  1'b0, 0, 0);
        do_instr(OP_STUR, 1'b0, 0, 0);
        do_instr(OP_STUR, 1'b0, 0, 1);
        do_instr(OP_LDUR, 1'b0, 1, 0);

        // Store stalled in MEMWRITE, then reset asserted in the middle of the cycle
        op_v = OP_STUR;
        cyc(ST_FETCH, 1'b1);
        cyc(ST_DECODE, 1'b0);
        cyc(ST_MEMADR, 1'b1);
        cyc(ST_MEMWRITE, 1'b0);
        @(posedge clk);
        #1 mem_ready = 1'b0;
        #1 chk("stall_mem_write", {31'd0, mem_write}, 32'd1);
        reset = 1'b0;
        rst_v = 1'b0;
        #1;
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_state", {28'd0, state_o}, 32'd0);
        chk("rst_outs", {16'd0, dut_outs}, 32'd0);
        cyc(ST_IDLE, 1'b1);
        rst_v = 1'b1;
        cyc(ST_IDLE, 1'b1);
        do_instr(OP_ADD, 1'b0, 0, 0);
        cyc(ST_FETCH, 1'b0);
        @(negedge clk);
        #1;
        chk("lat_count", lat_q.size(), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < lat_q.size()) chk($sformatf("lat%0d", i), lat_q[i], exp_lat[i]);
        end

`ifdef MC_PERF_CNT_EN
        rst_v = 1'b0;
        cyc(ST_IDLE, 1'b0);
        #1;
        chk("cycle_cnt_rst", {28'd0, cycle_cnt}, 32'd0);
        chk("instr_cnt_rst", {28'd0, instr_cnt}, 32'd0);
        rst_v = 1'b1;
        cyc(ST_IDLE, 1'b1);
        for (int i = 0; i < 5; i++) do_instr(OP_ADD, 1'b0, 0, 0);
        cyc(ST_FETCH, 1'b0);
        #1;
        chk("cycle_cnt_wrap", {28'd0, cycle_cnt}, 32'd4);
        chk("instr_cnt", {28'd0, instr_cnt}, 32'd5);
`endif

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0 || chk_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked", exp_q.size() + chk_q.size());
            $fatal(1, "expectation queues did not drain");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
